alarm_trigger: RTL and testbench

Downstream consumer of the alarm digit counters and the time-of-day digit counters. Compares the packed BCD alarm time against the current time and rings on the rising edge of a match. Runs a ring/snooze state machine that is timed in seconds by the 1 Hz tick from the seconds counter. Output drives the buzzer/LED and the display's status field.

---
 rtl/alarm_trigger_if.sv | 24 ++
 rtl/alarm_trigger.sv | 132 +++++++++++++
 tb/tb_alarm_trigger.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_trigger_if.sv
// Signal bundle between the alarm/time-of-day counters, buttons and the alarm_trigger block.
// master drives switch, buttons, tick and times; slave returns ring and status fields.
interface alarm_trigger_if;
    logic        alarm_on;
    logic        time_tick;
    logic        stop;
    logic        snooze;
    logic [15:0] alarm_time;
    logic [15:0] cur_time;
    logic        ring;
    logic [1:0]  state;
    logic [8:0]  remain;
    logic [1:0]  snooze_left;

    modport master (
        output alarm_on, time_tick, stop, snooze, alarm_time, cur_time,
        input  ring, state, remain, snooze_left
    );

    modport slave (
        input  alarm_on, time_tick, stop, snooze, alarm_time, cur_time,
        output ring, state, remain, snooze_left
    );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm match detector with ring/snooze state machine timed by the 1 Hz tick.
// Define ALARM_BLINK_EN to make ring toggle on every tick while ringing instead of holding steady.
module alarm_trigger #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic           i_clk,
    input  logic           i_reset,
    alarm_trigger_if.slave io_alarm
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_RINGING = 2'd2;
    localparam logic [1:0] S_SNOOZE  = 2'd3;

    localparam logic [8:0] RING_LD   = 9'(RING_SEC);
    localparam logic [8:0] SNOOZE_LD = 9'(SNOOZE_SEC);
    localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

    logic [1:0] r_state;
    logic [8:0] r_remain;
    logic [1:0] r_snooze_left;
    logic       r_ring;
    logic       r_match_d;

    logic       w_match;
    logic       w_trig;
    logic [1:0] w_state_nx;
    logic [8:0] w_remain_nx;
    logic [1:0] w_snooze_left_nx;
    logic       w_ring_nx;

    // Edge of the match, so a whole matching minute yields a single trigger.
    assign w_match = (io_alarm.alarm_time == io_alarm.cur_time);
    assign w_trig  = w_match & ~r_match_d;

    always_comb begin
        w_state_nx       = r_state;
        w_remain_nx      = r_remain;
        w_snooze_left_nx = r_snooze_left;
        w_ring_nx        = 1'b0;
        if (!io_alarm.alarm_on) begin
            w_state_nx       = S_IDLE;
            w_remain_nx      = 9'd0;
            w_snooze_left_nx = SNZ_MAX;
        end else begin
            case (r_state)
                S_IDLE: w_state_nx = S_ARMED;
                S_ARMED: begin
                    if (w_trig) begin
                        w_state_nx  = S_RINGING;
                        w_remain_nx = RING_LD;
                        w_ring_nx   = 1'b1;
                    end
                end
                S_RINGING: begin
                    w_ring_nx = r_ring;
                    if (io_alarm.stop) begin
                        w_state_nx       = S_ARMED;
                        w_remain_nx      = 9'd0;
                        w_snooze_left_nx = SNZ_MAX;
                        w_ring_nx        = 1'b0;
                    end else if (io_alarm.snooze && (r_snooze_left != 2'd0)) begin
                        w_state_nx       = S_SNOOZE;
                        w_remain_nx      = SNOOZE_LD;
                        w_snooze_left_nx = r_snooze_left - 2'd1;
                        w_ring_nx        = 1'b0;
                    end else if (io_alarm.time_tick) begin
                        // Compare with <= 1 so remain can never wrap below zero.
                        if (r_remain <= 9'd1) begin
                            w_state_nx       = S_ARMED;
                            w_remain_nx      = 9'd0;
                            w_snooze_left_nx = SNZ_MAX;
                            w_ring_nx        = 1'b0;
                        end else begin
                            w_remain_nx = r_remain - 9'd1;
`ifdef ALARM_BLINK_EN
                            w_ring_nx   = ~r_ring;
`else
                            w_ring_nx   = 1'b1;
`endif
                        end
                    end
                end
                S_SNOOZE: begin
                    if (io_alarm.stop) begin
                        w_state_nx       = S_ARMED;
                        w_remain_nx      = 9'd0;
                        w_snooze_left_nx = SNZ_MAX;
                    end else if (io_alarm.time_tick) begin
                        if (r_remain <= 9'd1) begin
                            w_state_nx  = S_RINGING;
                            w_remain_nx = RING_LD;
                            w_ring_nx   = 1'b1;
                        end else begin
                            w_remain_nx = r_remain - 9'd1;
                        end
                    end
                end
                default: begin
                    w_state_nx  = S_IDLE;
                    w_remain_nx = 9'd0;
                end
            endcase
        end
    end

    // match_d resets high so a power-up coincidence of alarm and time does not ring.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_remain      <= 9'd0;
            r_snooze_left <= SNZ_MAX;
            r_ring        <= 1'b0;
            r_match_d     <= 1'b1;
        end else begin
            r_state       <= w_state_nx;
            r_remain      <= w_remain_nx;
            r_snooze_left <= w_snooze_left_nx;
            r_ring        <= w_ring_nx;
            r_match_d     <= w_match;
        end
    end

    assign io_alarm.ring        = r_ring;
    assign io_alarm.state       = r_state;
    assign io_alarm.remain      = r_remain;
    assign io_alarm.snooze_left = r_snooze_left;

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: vector table, directed ring/snooze sequences, then random traffic
// compared cycle by cycle against a behavioural model of the alarm rules.
module tb_alarm_trigger;

    localparam int RING   = 60;
    localparam int SNZ    = 300;
    localparam int MAXS   = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alarm_trigger_if u_if ();

    alarm_trigger #(
        .RING_SEC   (RING),
        .SNOOZE_SEC (SNZ),
        .MAX_SNOOZE (MAXS)
    ) u_dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .io_alarm (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode uses the documented output numbering.
    int m_mode;
    int m_remain;
    int m_left;
    int m_ring;
    bit m_prev_match;

    logic [15:0] cur_at;
    logic [15:0] cur_ct;
    bit          cur_on;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit on, input bit tk, input bit sp,
                              input bit sz, input logic [15:0] at, input logic [15:0] ct);
        bit match;
        bit fresh;
        match = (at == ct);
        fresh = match && !m_prev_match;
        if (r) begin
            m_mode = 0; m_remain = 0; m_left = MAXS; m_ring = 0; m_prev_match = 1'b1;
            return;
        end
        m_prev_match = match;
        if (!on) begin
            m_mode = 0; m_remain = 0; m_left = MAXS; m_ring = 0;
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (fresh) begin m_mode = 2; m_remain = RING; m_ring = 1; end
        end else if (m_mode == 2) begin
            if (sp) begin
                m_mode = 1; m_remain = 0; m_left = MAXS;
            end else if (sz && m_left > 0) begin
                m_mode = 3; m_remain = SNZ; m_left--;
            end else if (tk) begin
                if (m_remain == 1) begin
                    m_mode = 1; m_remain = 0; m_left = MAXS;
                end else begin
                    m_remain--;
                    m_ring = 1 - m_ring;
                end
            end
        end else begin
            if (sp) begin
                m_mode = 1; m_remain = 0; m_left = MAXS;
            end else if (tk) begin
                if (m_remain == 1) begin m_mode = 2; m_remain = RING; m_ring = 1; end
                else m_remain--;
            end
        end
`ifdef ALARM_BLINK_EN
        if (m_mode != 2) m_ring = 0;
`else
        m_ring = (m_mode == 2) ? 1 : 0;
`endif
    endtask

    task automatic cyc(input bit r, input bit on, input bit tk, input bit sp, input bit sz,
                       input logic [15:0] at, input logic [15:0] ct);
        rst               = r;
        u_if.alarm_on     = on;
        u_if.time_tick    = tk;
        u_if.stop         = sp;
        u_if.snooze       = sz;
        u_if.alarm_time   = at;
        u_if.cur_time     = ct;
        model_step(r, on, tk, sp, sz, at, ct);
        @(posedge clk);
        #1;
        chk("model_state", int'(u_if.state), m_mode);
        chk("model_ring", int'(u_if.ring), m_ring);
        chk("model_remain", int'(u_if.remain), m_remain);
        chk("model_snooze_left", int'(u_if.snooze_left), m_left);
    endtask

    task automatic step(input bit tk, input bit sp, input bit sz);
        cyc(1'b0, cur_on, tk, sp, sz, cur_at, cur_ct);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic trigger();
        cur_ct = 16'h0629;
        step(1'b0, 1'b0, 1'b0);
        cur_ct = 16'h0630;
        step(1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit          r;
        bit          on;
        bit          tk;
        bit          sp;
        bit          sz;
        logic [15:0] at;
        logic [15:0] ct;
        int          st;
        int          rg;
        int          rm;
        int          lf;
    } vec_t;

    vec_t vec [13];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        u_if.alarm_on = 1'b0; u_if.time_tick = 1'b0; u_if.stop = 1'b0; u_if.snooze = 1'b0;
        u_if.alarm_time = 16'h0000; u_if.cur_time = 16'h0000;

        //            r  on tk sp sz  alarm     cur       st rg rm   lf
        vec[0]  = '{1, 1, 0, 0, 0, 16'h0700, 16'h0700, 0, 0, 0,   3};
        vec[1]  = '{0, 1, 0, 0, 0, 16'h0700, 16'h0700, 1, 0, 0,   3};
        vec[2]  = '{0, 1, 0, 0, 0, 16'h0700, 16'h0700, 1, 0, 0,   3};
        vec[3]  = '{0, 1, 0, 0, 0, 16'h0630, 16'h0629, 1, 0, 0,   3};
        vec[4]  = '{0, 1, 0, 0, 0, 16'h0630, 16'h0630, 2, 1, 60,  3};
        vec[5]  = '{0, 1, 0, 0, 1, 16'h0630, 16'h0630, 3, 0, 300, 2};
        vec[6]  = '{0, 1, 1, 0, 0, 16'h0630, 16'h0630, 3, 0, 299, 2};
        vec[7]  = '{0, 1, 0, 0, 1, 16'h0630, 16'h0630, 3, 0, 299, 2};
        vec[8]  = '{0, 1, 0, 1, 0, 16'h0630, 16'h0630, 1, 0, 0,   3};
        vec[9]  = '{0, 1, 1, 0, 0, 16'h0630, 16'h0630, 1, 0, 0,   3};
        vec[10] = '{0, 0, 0, 0, 0, 16'h0630, 16'h0630, 0, 0, 0,   3};
        vec[11] = '{0, 1, 0, 0, 0, 16'h0630, 16'h0630, 1, 0, 0,   3};
        vec[12] = '{0, 1, 0, 0, 0, 16'h0630, 16'h0630, 1, 0, 0,   3};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            cyc(vec[i].r, vec[i].on, vec[i].tk, vec[i].sp, vec[i].sz, vec[i].at, vec[i].ct);
            chk($sformatf("vec%0d_state", i), int'(u_if.state), vec[i].st);
            chk($sformatf("vec%0d_ring", i), int'(u_if.ring), vec[i].rg);
            chk($sformatf("vec%0d_remain", i), int'(u_if.remain), vec[i].rm);
            chk($sformatf("vec%0d_left", i), int'(u_if.snooze_left), vec[i].lf);
        end

        cur_on = 1'b1;
        cur_at = 16'h0630;
        cur_ct = 16'h0630;

        // Auto-stop after RING ticks, then no re-ring inside the same minute.
        trigger();
        chk("auto_enter_state", int'(u_if.state), 2);
        chk("auto_enter_remain", int'(u_if.remain), RING);
        ticks(RING - 1);
        chk("auto_last_remain", int'(u_if.remain), 1);
        ticks(1);
        chk("auto_stop_state", int'(u_if.state), 1);
        chk("auto_stop_ring", int'(u_if.ring), 0);
        ticks(5);
        chk("no_reretrig_state", int'(u_if.state), 1);

        // Three snooze cycles, then a fourth snooze is ignored.
        trigger();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("snooze_state", int'(u_if.state), 3);
            chk("snooze_remain", int'(u_if.remain), SNZ);
            chk("snooze_left", int'(u_if.snooze_left), 2 - k);
            ticks(SNZ);
            chk("rering_state", int'(u_if.state), 2);
            chk("rering_remain", int'(u_if.remain), RING);
            chk("rering_ring", int'(u_if.ring), 1);
        end
        step(1'b0, 1'b0, 1'b1);
        chk("snooze4_state", int'(u_if.state), 2);
        chk("snooze4_left", int'(u_if.snooze_left), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("stop_reload_left", int'(u_if.snooze_left), 3);

        // stop, snooze and tick together: stop wins, no decrement.
        trigger();
        ticks(RING - 5);
        chk("pre_combo_remain", int'(u_if.remain), 5);
        step(1'b1, 1'b1, 1'b1);
        chk("combo_state", int'(u_if.state), 1);
        chk("combo_remain", int'(u_if.remain), 0);
        chk("combo_left", int'(u_if.snooze_left), 3);

        // alarm_on drop in SNOOZE.
        trigger();
        step(1'b0, 1'b0, 1'b1);
        ticks(SNZ - 120);
        chk("pre_off_remain", int'(u_if.remain), 120);
        cur_on = 1'b0;
        step(1'b0, 1'b0, 0);
        chk("off_state", int'(u_if.state), 0);
        chk("off_ring", int'(u_if.ring), 0);
        chk("off_remain", int'(u_if.remain), 0);
        cur_on = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("rearm_state", int'(u_if.state), 1);
        ticks(3);
        chk("rearm_no_ring", int'(u_if.ring), 0);

        // Ring pattern across tick boundaries.
        trigger();
        chk("pattern0", int'(u_if.ring), 1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
`ifdef ALARM_BLINK_EN
            chk($sformatf("pattern%0d", i), int'(u_if.ring), (i % 2 == 0) ? 1 : 0);
`else
            chk($sformatf("pattern%0d", i), int'(u_if.ring), 1);
`endif
        end
        step(1'b0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bit r;
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) cur_on = ~cur_on;
            else if (!cur_on && $urandom_range(0, 3) == 0) cur_on = 1'b1;
            if ($urandom_range(0, 9) == 0)
                cur_ct = ($urandom_range(0, 2) == 0) ? 16'h0629 : cur_at;
            if ($urandom_range(0, 199) == 0)
                cur_at = ($urandom_range(0, 1) == 0) ? cur_ct : 16'h1245;
            cyc(r, cur_on, ($urandom_range(0, 1) == 0), ($urandom_range(0, 79) == 0),
                ($urandom_range(0, 19) == 0), cur_at, cur_ct);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
